// File: rtl/clock_enable.sv
// Divides sysclk by DIVISOR into registered end-of-period / mid-period strobes and a square wave.
// Define CLOCKEN_CLKEN2_EN to generate the mid-period strobe clken2; otherwise it is tied low.
module clock_enable #(
    parameter int unsigned DIVISOR = 8
) (
    input  logic sysclk,
    input  logic reset,
    output logic clken,
    output logic clken2,
    output logic slowclk
);

    localparam int unsigned CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned HALF = DIVISOR / 2;

    localparam logic [CW-1:0] LastPhase  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HalfPhase  = CW'(HALF);
    localparam logic [CW-1:0] LowEnd     = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clken_q, slowclk_q;

    always_comb begin
        cnt_d = (cnt_q == LastPhase) ? '0 : cnt_q + CW'(1);
    end

    // Outputs decode cnt_d so each flop holds the decode of the phase cnt_q is entering.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_q     <= LastPhase;
            clken_q   <= 1'b0;
            slowclk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clken_q   <= (cnt_d == LastPhase);
            slowclk_q <= (cnt_d >= HalfPhase);
        end
    end

    assign clken   = clken_q;
    assign slowclk = slowclk_q;

`ifdef CLOCKEN_CLKEN2_EN
    logic clken2_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            clken2_q <= 1'b0;
        end else begin
            clken2_q <= (cnt_d == LowEnd);
        end
    end

    assign clken2 = clken2_q;
`else
    logic unused_low_end;
    assign unused_low_end = ^LowEnd;
    assign clken2         = 1'b0;
`endif

endmodule

// File: tb/tb_clock_enable.sv
// Self-checking bench: three clock_enable instances (DIVISOR 8, 2, 5) against a cycle-count model.
module tb_clock_enable;

    localparam int NDUT = 3;
    localparam int DIVS [NDUT] = '{8, 2, 5};

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic rst    [NDUT];
    logic ck     [NDUT];
    logic ck2    [NDUT];
    logic sc     [NDUT];

    clock_enable #(.DIVISOR(8)) u_div8 (
        .sysclk (sysclk), .reset (rst[0]), .clken (ck[0]), .clken2 (ck2[0]), .slowclk (sc[0])
    );
    clock_enable #(.DIVISOR(2)) u_div2 (
        .sysclk (sysclk), .reset (rst[1]), .clken (ck[1]), .clken2 (ck2[1]), .slowclk (sc[1])
    );
    clock_enable #(.DIVISOR(5)) u_div5 (
        .sysclk (sysclk), .reset (rst[2]), .clken (ck[2]), .clken2 (ck2[2]), .slowclk (sc[2])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cycle_no = 0;

    // Model state: cycles elapsed since the last reset release, and whether we are running.
    int n_since [NDUT];
    bit running [NDUT];

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %b expected %b", tag, cycle_no, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        cycle_no++;
        for (int i = 0; i < NDUT; i++) begin
            if (rst[i]) begin
                running[i] = 1'b0;
            end else if (!running[i]) begin
                running[i] = 1'b1;
                n_since[i] = 0;
            end else begin
                n_since[i]++;
            end
        end
        @(negedge sysclk);
        for (int i = 0; i < NDUT; i++) begin
            int  d;
            int  ph;
            bit  e_ck, e_ck2, e_sc;
            d     = DIVS[i];
            ph    = n_since[i] % d;
            e_ck  = running[i] && (ph == d - 1);
            e_sc  = running[i] && (ph >= d / 2);
`ifdef CLOCKEN_CLKEN2_EN
            e_ck2 = running[i] && (ph == d / 2 - 1);
`else
            e_ck2 = 1'b0;
`endif
            check_eq($sformatf("clken[D=%0d]", d), ck[i], e_ck);
            check_eq($sformatf("clken2[D=%0d]", d), ck2[i], e_ck2);
            check_eq($sformatf("slowclk[D=%0d]", d), sc[i], e_sc);
            check_eq($sformatf("overlap[D=%0d]", d), ck[i] & ck2[i], 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst[i]     = 1'b1;
            running[i] = 1'b0;
            n_since[i] = 0;
        end

        // Reset for 3 cycles, then free-run 64 cycles.
        repeat (3) tick();
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;
        repeat (64) tick();

        // Restart DIVISOR=8, then abort its period with a 1-cycle reset at phase 5.
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (5) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (20) tick();

        // Randomised sporadic resets of random length.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                if (rst[i]) rst[i] = ($urandom_range(0, 2) == 0);
                else        rst[i] = ($urandom_range(0, 29) == 0);
            end
            tick();
        end

        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
